// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM and WB pipeline stages of the integer core.
//
// Holds the EX/MEM and MEM/WB pipeline registers. It drives the data-memory
// request/ready handshake, which has a bounded wait and an abort on timeout.
// It also aligns and extends load data and builds the byte lanes for stores.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   *_ex                   instruction leaving EX (result/address, store data,
//                          destination, control bits, funct3, flush)
//   dmem_*                 data-memory request (req/we/addr/wdata/wstrb) and
//                          response (rdata/ready)
//   ALUResult_mem, rdAddr_mem, RegWrite_mem
//                          EX/MEM forwarding sources
//   RegWriteData_wb, rdAddr_wb, RegWrite_wb
//                          MEM/WB forwarding sources and register-file write
//   stall_mem              freezes IF/ID/EX and EX/MEM while an access is pending
//   mem_err                one-cycle pulse when an access is aborted on timeout
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic [2:0]  funct3_ex,
  input  logic        flush_ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        stall_mem,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  // Picks the addressed byte/half out of the read word and extends it.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // State and counter
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  // EX/MEM register
  logic [31:0] alu_mem_q, alu_mem_d;
  logic [31:0] wdata_mem_q, wdata_mem_d;
  logic [4:0]  rd_mem_q, rd_mem_d;
  logic        rw_mem_q, rw_mem_d;
  logic        mr_mem_q, mr_mem_d;
  logic        mw_mem_q, mw_mem_d;
  logic        m2r_mem_q, m2r_mem_d;
  logic [2:0]  f3_mem_q, f3_mem_d;

  // MEM/WB register
  logic [31:0] alu_wb_q, alu_wb_d;
  logic [31:0] ld_wb_q, ld_wb_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic        rw_wb_q, rw_wb_d;
  logic        m2r_wb_q, m2r_wb_d;

  logic        mem_op;
  logic        stall;
  logic        aborting;

  assign mem_op   = mr_mem_q | mw_mem_q;
  assign aborting = (state_q == ST_ABORT);

  // FSM state and wait-counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; ready is tested before the timeout so it wins a tie
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !dmem_ready) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = ST_ABORT;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // FSM outputs: request, stall and error pulse
  always_comb begin
    dmem_req = 1'b0;
    stall    = 1'b0;
    mem_err  = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        dmem_req = mem_op;
        stall    = mem_op & ~dmem_ready;
      end
      ST_ABORT: begin
        mem_err = 1'b1;
      end
      default: begin
        dmem_req = 1'b0;
      end
    endcase
  end

  assign stall_mem = stall;

  // Store lane generation from the low address bits and access width
  always_comb begin
    dmem_wstrb = 4'b0000;
    dmem_wdata = wdata_mem_q;
    case (f3_mem_q[1:0])
      2'b00: begin
        dmem_wstrb = 4'b0001 << alu_mem_q[1:0];
        dmem_wdata = {4{wdata_mem_q[7:0]}};
      end
      2'b01: begin
        dmem_wstrb = alu_mem_q[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{wdata_mem_q[15:0]}};
      end
      default: begin
        dmem_wstrb = 4'b1111;
        dmem_wdata = wdata_mem_q;
      end
    endcase
    if (!mw_mem_q) begin
      dmem_wstrb = 4'b0000;
    end else begin
      dmem_wstrb = dmem_wstrb;
    end
  end

  assign dmem_we   = mw_mem_q;
  assign dmem_addr = {alu_mem_q[31:2], 2'b00};

  // EX/MEM next value: hold on stall, bubble on flush, else load
  always_comb begin
    alu_mem_d   = alu_mem_q;
    wdata_mem_d = wdata_mem_q;
    rd_mem_d    = rd_mem_q;
    rw_mem_d    = rw_mem_q;
    mr_mem_d    = mr_mem_q;
    mw_mem_d    = mw_mem_q;
    m2r_mem_d   = m2r_mem_q;
    f3_mem_d    = f3_mem_q;
    if (!stall) begin
      alu_mem_d   = ALUResult_ex;
      wdata_mem_d = MemWriteData_ex;
      rd_mem_d    = rdAddr_ex;
      m2r_mem_d   = MemtoReg_ex;
      f3_mem_d    = funct3_ex;
      if (flush_ex) begin
        rw_mem_d = 1'b0;
        mr_mem_d = 1'b0;
        mw_mem_d = 1'b0;
      end else begin
        rw_mem_d = RegWrite_ex;
        mr_mem_d = MemRead_ex;
        mw_mem_d = MemWrite_ex;
      end
    end else begin
      alu_mem_d = alu_mem_q;
    end
  end

  // EX/MEM register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_mem_q   <= 32'd0;
      wdata_mem_q <= 32'd0;
      rd_mem_q    <= 5'd0;
      rw_mem_q    <= 1'b0;
      mr_mem_q    <= 1'b0;
      mw_mem_q    <= 1'b0;
      m2r_mem_q   <= 1'b0;
      f3_mem_q    <= 3'd0;
    end else begin
      alu_mem_q   <= alu_mem_d;
      wdata_mem_q <= wdata_mem_d;
      rd_mem_q    <= rd_mem_d;
      rw_mem_q    <= rw_mem_d;
      mr_mem_q    <= mr_mem_d;
      mw_mem_q    <= mw_mem_d;
      m2r_mem_q   <= m2r_mem_d;
      f3_mem_q    <= f3_mem_d;
    end
  end

  // MEM/WB next value: a stalled or aborted access retires as a bubble
  always_comb begin
    alu_wb_d = alu_mem_q;
    ld_wb_d  = load_extract(f3_mem_q, alu_mem_q[1:0], dmem_rdata);
    rd_wb_d  = rd_mem_q;
    m2r_wb_d = m2r_mem_q;
    if (stall || aborting) begin
      rw_wb_d = 1'b0;
    end else begin
      rw_wb_d = rw_mem_q;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_wb_q <= 32'd0;
      ld_wb_q  <= 32'd0;
      rd_wb_q  <= 5'd0;
      rw_wb_q  <= 1'b0;
      m2r_wb_q <= 1'b0;
    end else begin
      alu_wb_q <= alu_wb_d;
      ld_wb_q  <= ld_wb_d;
      rd_wb_q  <= rd_wb_d;
      rw_wb_q  <= rw_wb_d;
      m2r_wb_q <= m2r_wb_d;
    end
  end

  // x0 is never a forwarding source nor a write target
  assign ALUResult_mem   = alu_mem_q;
  assign rdAddr_mem      = rd_mem_q;
  assign RegWrite_mem    = rw_mem_q & (rd_mem_q != 5'd0);
  assign rdAddr_wb       = rd_wb_q;
  assign RegWrite_wb     = rw_wb_q & (rd_wb_q != 5'd0);
  assign RegWriteData_wb = m2r_wb_q ? ld_wb_q : alu_wb_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResult_ex, MemWriteData_ex;
  logic [4:0]  rdAddr_ex;
  logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, flush_ex;
  logic [2:0]  funct3_ex;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] ALUResult_mem, RegWriteData_wb;
  logic [4:0]  rdAddr_mem, rdAddr_wb;
  logic        RegWrite_mem, RegWrite_wb, stall_mem, mem_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .rdAddr_ex(rdAddr_ex), .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
    .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex), .funct3_ex(funct3_ex),
    .flush_ex(flush_ex),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem), .RegWrite_mem(RegWrite_mem),
    .RegWriteData_wb(RegWriteData_wb), .rdAddr_wb(rdAddr_wb), .RegWrite_wb(RegWrite_wb),
    .stall_mem(stall_mem), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic m2r,
                        input logic [2:0] f3, input logic fl);
    ALUResult_ex    = alu;
    MemWriteData_ex = wd;
    rdAddr_ex       = rd;
    RegWrite_ex     = rw;
    MemRead_ex      = mr;
    MemWrite_ex     = mw;
    MemtoReg_ex     = m2r;
    funct3_ex       = f3;
    flush_ex        = fl;
  endtask

  task automatic set_nop();
    set_ex(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  // Zero-wait load: ready in the MEM cycle, result visible after the next edge
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [31:0] exp);
    set_ex(addr, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, f3, 1'b0);
    tick();
    set_nop();
    dmem_ready = 1'b1;
    dmem_rdata = rdata;
    #1;
    check_eq({tag, "_stall"}, {31'd0, stall_mem}, 32'd0);
    check_eq({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
    check_eq({tag, "_addr"}, dmem_addr, exp_addr);
    tick();
    dmem_ready = 1'b0;
    #1;
    check_eq({tag, "_data"}, RegWriteData_wb, exp);
    check_eq({tag, "_rw_wb"}, {31'd0, RegWrite_wb}, 32'd1);
  endtask

  // lw that never gets ready: 5 stall cycles, one abort cycle, then a follow-on ALU op
  task automatic lw_timeout(input string tag);
    int stalls;
    int k;
    stalls = 0;
    k = 0;
    set_ex(32'h0000_0300, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0);
    tick();
    set_nop();
    dmem_ready = 1'b0;
    #1;
    while (mem_err !== 1'b1 && k < 20) begin
      if (stall_mem === 1'b1) stalls++;
      tick();
      k++;
    end
    check_eq({tag, "_stalls"}, stalls, 32'd5);
    check_eq({tag, "_err"}, {31'd0, mem_err}, 32'd1);
    check_eq({tag, "_req_abort"}, {31'd0, dmem_req}, 32'd0);
    check_eq({tag, "_stall_abort"}, {31'd0, stall_mem}, 32'd0);
    check_eq({tag, "_rw_wb_abort"}, {31'd0, RegWrite_wb}, 32'd0);
    set_ex(32'h0000_0055, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    set_nop();
    #1;
    check_eq({tag, "_err_pulse"}, {31'd0, mem_err}, 32'd0);
    check_eq({tag, "_next_alu"}, ALUResult_mem, 32'h0000_0055);
    check_eq({tag, "_next_rw"}, {31'd0, RegWrite_mem}, 32'd1);
    check_eq({tag, "_bubble_wb"}, {31'd0, RegWrite_wb}, 32'd0);
    tick();
    check_eq({tag, "_next_wb"}, RegWriteData_wb, 32'h0000_0055);
    check_eq({tag, "_next_rd"}, {27'd0, rdAddr_wb}, 32'd3);
    check_eq({tag, "_next_rwwb"}, {31'd0, RegWrite_wb}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    set_nop();
    dmem_rdata = 32'd0;
    dmem_ready = 1'b0;
    #12;
    check_eq("rst_req", {31'd0, dmem_req}, 32'd0);
    check_eq("rst_stall", {31'd0, stall_mem}, 32'd0);
    check_eq("rst_err", {31'd0, mem_err}, 32'd0);
    check_eq("rst_rw_mem", {31'd0, RegWrite_mem}, 32'd0);
    check_eq("rst_rw_wb", {31'd0, RegWrite_wb}, 32'd0);
    check_eq("rst_wbdata", RegWriteData_wb, 32'd0);
    check_eq("rst_addr", dmem_addr, 32'd0);
    reset = 1'b0;
    tick();

    // ALU passthrough
    set_ex(32'h1234_5678, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    set_nop();
    #1;
    check_eq("alu_mem", ALUResult_mem, 32'h1234_5678);
    check_eq("alu_rw_mem", {31'd0, RegWrite_mem}, 32'd1);
    check_eq("alu_req", {31'd0, dmem_req}, 32'd0);
    tick();
    check_eq("alu_wb", RegWriteData_wb, 32'h1234_5678);
    check_eq("alu_rd_wb", {27'd0, rdAddr_wb}, 32'd5);
    check_eq("alu_rw_wb", {31'd0, RegWrite_wb}, 32'd1);
    check_eq("alu_req2", {31'd0, dmem_req}, 32'd0);

    // Loads with alignment/extension
    do_load("lb",  32'h0000_0103, 3'b000, 32'h80AA_BBCC, 32'h0000_0100, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_0103, 3'b100, 32'h80AA_BBCC, 32'h0000_0100, 32'h0000_0080);
    do_load("lh",  32'h0000_0102, 3'b001, 32'h80AA_BBCC, 32'h0000_0100, 32'hFFFF_80AA);
    do_load("lhu", 32'h0000_0100, 3'b101, 32'h80AA_BBCC, 32'h0000_0100, 32'h0000_BBCC);
    do_load("lw",  32'h0000_0104, 3'b010, 32'hCAFE_F00D, 32'h0000_0104, 32'hCAFE_F00D);

    // sh with three wait states; EX inputs wiggle during the stall
    set_ex(32'h0000_0202, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0);
    tick();
    set_ex(32'hDEAD_BEEF, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    dmem_ready = 1'b0;
    #1;
    check_eq("sh_addr", dmem_addr, 32'h0000_0200);
    check_eq("sh_strb", {28'd0, dmem_wstrb}, 32'h0000_000C);
    check_eq("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    check_eq("sh_we", {31'd0, dmem_we}, 32'd1);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        dmem_ready = 1'b1;
        set_nop();
      end
      #1;
      check_eq($sformatf("sh_stall_c%0d", c), {31'd0, stall_mem}, (c < 4) ? 32'd1 : 32'd0);
      if (c == 2 || c == 3) begin
        check_eq($sformatf("sh_hold_c%0d", c), ALUResult_mem, 32'h0000_0202);
        check_eq($sformatf("sh_rwwb_c%0d", c), {31'd0, RegWrite_wb}, 32'd0);
      end
      tick();
    end
    dmem_ready = 1'b0;
    #1;
    check_eq("sh_after_req", {31'd0, dmem_req}, 32'd0);
    check_eq("sh_after_rwmem", {31'd0, RegWrite_mem}, 32'd0);

    // sb and sw lanes, zero-wait
    set_ex(32'h0000_0401, 32'h1234_56AB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    tick();
    set_nop();
    dmem_ready = 1'b1;
    #1;
    check_eq("sb_strb", {28'd0, dmem_wstrb}, 32'h0000_0002);
    check_eq("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    check_eq("sb_stall", {31'd0, stall_mem}, 32'd0);
    set_ex(32'h0000_0500, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0);
    tick();
    set_nop();
    #1;
    check_eq("sw_strb", {28'd0, dmem_wstrb}, 32'h0000_000F);
    check_eq("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
    tick();
    dmem_ready = 1'b0;

    // Timeout abort, then the next instruction proceeds
    lw_timeout("to");

    // Ready arriving exactly at counter==TIMEOUT beats the abort
    set_ex(32'h0000_0304, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0);
    tick();
    set_nop();
    dmem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check_eq($sformatf("rw_stall_c%0d", c), {31'd0, stall_mem}, 32'd1);
      tick();
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h1122_3344;
    #1;
    check_eq("rw_stall_last", {31'd0, stall_mem}, 32'd0);
    check_eq("rw_err_last", {31'd0, mem_err}, 32'd0);
    tick();
    dmem_ready = 1'b0;
    #1;
    check_eq("rw_err_after", {31'd0, mem_err}, 32'd0);
    check_eq("rw_data", RegWriteData_wb, 32'h1122_3344);
    check_eq("rw_rd", {27'd0, rdAddr_wb}, 32'd11);
    check_eq("rw_rwwb", {31'd0, RegWrite_wb}, 32'd1);

    // x0 destination is never written or forwarded
    set_ex(32'h0000_0077, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    set_nop();
    #1;
    check_eq("x0_rw_mem", {31'd0, RegWrite_mem}, 32'd0);
    tick();
    check_eq("x0_rw_wb", {31'd0, RegWrite_wb}, 32'd0);

    // Flushed store issues no request
    set_ex(32'h0000_0400, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1);
    tick();
    set_nop();
    #1;
    check_eq("flush_req", {31'd0, dmem_req}, 32'd0);
    check_eq("flush_strb", {28'd0, dmem_wstrb}, 32'd0);

    // Reset asserted in WAIT
    set_ex(32'h0000_0300, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0);
    tick();
    set_nop();
    tick();
    check_eq("rstw_pre_stall", {31'd0, stall_mem}, 32'd1);
    check_eq("rstw_pre_rw", {31'd0, RegWrite_mem}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_eq("rstw_req", {31'd0, dmem_req}, 32'd0);
    check_eq("rstw_stall", {31'd0, stall_mem}, 32'd0);
    check_eq("rstw_rw_mem", {31'd0, RegWrite_mem}, 32'd0);
    check_eq("rstw_rw_wb", {31'd0, RegWrite_wb}, 32'd0);
    #1;
    reset = 1'b0;
    tick();
    check_eq("rstw_idle_req", {31'd0, dmem_req}, 32'd0);
    // A fresh timeout run needs exactly 5 stall cycles only if the FSM restarted from IDLE
    lw_timeout("rstw");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
